boot_loader: RTL and testbench



---
 rtl/boot_loader_pkg.sv | 18 +
 rtl/boot_loader_word_packer.sv | 37 +++
 rtl/boot_loader.sv | 166 ++++++++++++++++
 tb/tb_boot_loader.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/boot_loader_pkg.sv
// Shared types and constants for the flash boot loader.
// Optional checksum stage is enabled by defining BOOT_LOADER_CHECKSUM_EN.
package boot_loader_pkg;

    typedef enum logic [2:0] {
        CNT_LO,
        CNT_HI,
        DATA,
        WRITE,
        CHK,
        DONE,
        ERR
    } boot_state_t;

    localparam int BYTES_PER_WORD = 4;
    localparam int LANE_W         = 8;

endpackage

// File: rtl/boot_loader_word_packer.sv
// Byte-lane packer: assembles little-endian words one byte at a time.
// The first byte after a clear lands in bits [7:0].
module boot_word_packer
    import boot_loader_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic             clear_i,
    input  logic [7:0]       byte_i,
    output logic [WIDTH-1:0] word_o,
    output logic             word_full_o
);

    logic [1:0]       idx_q;
    logic [WIDTH-1:0] word_q;

    // Write the incoming byte into the lane selected by the index, then advance.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge values of its neighbours.
        if (rst || clear_i) begin
            idx_q  <= '0;
            word_q <= '0;
        end else if (load_i) begin
            word_q[{idx_q, 3'b000} +: LANE_W] <= byte_i;
            idx_q                             <= idx_q + 2'd1;
        end
    end

    // The next load completes the word.
    assign word_full_o = (idx_q == 2'(BYTES_PER_WORD - 1));
    assign word_o      = word_q;

endmodule

// File: rtl/boot_loader.sv
// Boot loader: receives "count_lo, count_hi, payload" over valid/ready, packs
// payload bytes into words, writes them to flash at consecutive addresses and
// releases the core reset once the image is loaded.
// Define BOOT_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
module boot_loader
    import boot_loader_pkg::*;
#(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] BASE_ADDR = '0,
    parameter int               MAX_WORDS = 512
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       rx_data,
    input  logic             rx_valid,
    output logic             rx_ready,
    output logic [WIDTH-1:0] flash_addr,
    output logic [WIDTH-1:0] flash_data,
    output logic             flash_en,
    output logic             core_rst,
    output logic             done,
    output logic             err
);

    localparam logic [15:0] MAX_N = 16'(MAX_WORDS);

    boot_state_t      state_q;
    logic [7:0]       cnt_lo_q;
    logic [15:0]      remaining_q;
    logic [WIDTH-1:0] flash_addr_q;
    logic             rx_ready_q;
    logic             flash_en_q;
    logic             core_rst_q;
    logic             done_q;
    logic             err_q;
`ifdef BOOT_LOADER_CHECKSUM_EN
    logic [7:0]       csum_q;
`endif

    logic        transfer;
    logic [15:0] count_n;
    logic        word_full;
    logic        pk_load;
    logic        pk_clear;

    assign transfer = rx_valid && rx_ready_q;
    assign count_n  = {rx_data, cnt_lo_q};
    assign pk_load  = transfer && (state_q == DATA);
    // Start every image with an empty lane index.
    assign pk_clear = transfer && (state_q == CNT_HI);

    boot_word_packer #(.WIDTH(WIDTH)) u_packer (
        .clk         (clk),
        .rst         (rst),
        .load_i      (pk_load),
        .clear_i     (pk_clear),
        .byte_i      (rx_data),
        .word_o      (flash_data),
        .word_full_o (word_full)
    );

    // Protocol FSM; outputs are registered and updated together with the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= CNT_LO;
            cnt_lo_q     <= '0;
            remaining_q  <= '0;
            flash_addr_q <= BASE_ADDR;
            rx_ready_q   <= 1'b0;
            flash_en_q   <= 1'b0;
            core_rst_q   <= 1'b1;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
`ifdef BOOT_LOADER_CHECKSUM_EN
            csum_q       <= '0;
`endif
        end else begin
            case (state_q)
                CNT_LO: begin
                    rx_ready_q <= 1'b1;
                    if (transfer) begin
                        cnt_lo_q <= rx_data;
                        state_q  <= CNT_HI;
                    end
                end
                CNT_HI: begin
                    if (transfer) begin
                        if (count_n > MAX_N) begin
                            state_q    <= ERR;
                            rx_ready_q <= 1'b0;
                            err_q      <= 1'b1;
                        end else if (count_n == 16'd0) begin
`ifdef BOOT_LOADER_CHECKSUM_EN
                            state_q    <= CHK;
`else
                            state_q    <= DONE;
                            rx_ready_q <= 1'b0;
                            core_rst_q <= 1'b0;
                            done_q     <= 1'b1;
`endif
                        end else begin
                            remaining_q <= count_n;
                            state_q     <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (transfer) begin
`ifdef BOOT_LOADER_CHECKSUM_EN
                        csum_q <= csum_q ^ rx_data;
`endif
                        if (word_full) begin
                            state_q    <= WRITE;
                            rx_ready_q <= 1'b0;
                            flash_en_q <= 1'b1;
                        end
                    end
                end
                WRITE: begin
                    flash_en_q   <= 1'b0;
                    flash_addr_q <= flash_addr_q + WIDTH'(BYTES_PER_WORD);
                    remaining_q  <= remaining_q - 16'd1;
                    if (remaining_q == 16'd1) begin
`ifdef BOOT_LOADER_CHECKSUM_EN
                        state_q    <= CHK;
                        rx_ready_q <= 1'b1;
`else
                        state_q    <= DONE;
                        core_rst_q <= 1'b0;
                        done_q     <= 1'b1;
`endif
                    end else begin
                        state_q    <= DATA;
                        rx_ready_q <= 1'b1;
                    end
                end
`ifdef BOOT_LOADER_CHECKSUM_EN
                CHK: begin
                    if (transfer) begin
                        rx_ready_q <= 1'b0;
                        if (rx_data == csum_q) begin
                            state_q    <= DONE;
                            core_rst_q <= 1'b0;
                            done_q     <= 1'b1;
                        end else begin
                            state_q <= ERR;
                            err_q   <= 1'b1;
                        end
                    end
                end
`endif
                default: begin
                    // DONE and ERR hold until reset.
                end
            endcase
        end
    end

    assign rx_ready   = rx_ready_q;
    assign flash_addr = flash_addr_q;
    assign flash_en   = flash_en_q;
    assign core_rst   = core_rst_q;
    assign done       = done_q;
    assign err        = err_q;

endmodule

// File: tb/tb_boot_loader.sv
// Scoreboard bench for boot_loader: the stimulus side queues expected flash
// writes, a monitor pops and compares on every flash_en pulse.
module tb_boot_loader;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic [31:0] flash_addr;
    logic [31:0] flash_data;
    logic        flash_en;
    logic        core_rst;
    logic        done;
    logic        err;

    int  checks = 0;
    int  failures = 0;
    int  pulses = 0;
    wr_t exp_q[$];

    logic [7:0] img [14] = '{8'h03, 8'h00, 8'h33, 8'h46, 8'hC6, 8'h00, 8'h13,
                             8'h06, 8'h16, 8'h00, 8'h6F, 8'hF0, 8'hDF, 8'hFF};

    always #5 clk = ~clk;

    boot_loader dut (
        .clk        (clk),
        .rst        (rst),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .flash_addr (flash_addr),
        .flash_data (flash_data),
        .flash_en   (flash_en),
        .core_rst   (core_rst),
        .done       (done),
        .err        (err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every write strobe must match the oldest queued expectation.
    always @(negedge clk) begin
        if (flash_en === 1'b1) begin
            pulses++;
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_write: got addr 0x%08h data 0x%08h expected none",
                         flash_addr, flash_data);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                if (flash_addr !== e.addr || flash_data !== e.data) begin
                    failures++;
                    $display("FAIL write: got (0x%08h,0x%08h) expected (0x%08h,0x%08h)",
                             flash_addr, flash_data, e.addr, e.data);
                end
            end
        end
    end

    // All stimulus is applied at the falling edge.
    task automatic do_reset(input int cycles);
        rst = 1'b1;
        rx_valid = 1'b0;
        repeat (cycles) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gap);
        int budget = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        while (rx_ready !== 1'b1) begin
            @(negedge clk);
            budget++;
            if (budget > 200) begin
                check("rx_ready_timeout", 32'(rx_ready), 32'd1);
                rx_valid = 1'b0;
                return;
            end
        end
        @(negedge clk);
        rx_valid = 1'b0;
        rx_data  = 8'hA5;
        if (gap) @(negedge clk);
    endtask

    task automatic push_img_writes();
        exp_q.push_back('{addr: 32'h0, data: 32'h00c64633});
        exp_q.push_back('{addr: 32'h4, data: 32'h00160613});
        exp_q.push_back('{addr: 32'h8, data: 32'hffdff06f});
    endtask

    task automatic send_img(input bit gap);
        for (int i = 0; i < 14; i++) send_byte(img[i], gap);
    endtask

    task automatic wait_end(input string name);
        int budget = 0;
        while (done !== 1'b1 && err !== 1'b1 && budget < 100) begin
            @(negedge clk);
            budget++;
        end
        check({name, "_terminated"}, 32'(done === 1'b1 || err === 1'b1), 32'd1);
    endtask

    task automatic expect_done(input string name, input int n_pulses);
        wait_end(name);
        check({name, "_done"}, 32'(done), 32'd1);
        check({name, "_core_rst"}, 32'(core_rst), 32'd0);
        check({name, "_err"}, 32'(err), 32'd0);
        check({name, "_rx_ready"}, 32'(rx_ready), 32'd0);
        check({name, "_pulses"}, 32'(pulses), 32'(n_pulses));
        check({name, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic expect_err(input string name, input int n_pulses);
        wait_end(name);
        check({name, "_err"}, 32'(err), 32'd1);
        check({name, "_core_rst"}, 32'(core_rst), 32'd1);
        check({name, "_done"}, 32'(done), 32'd0);
        check({name, "_pulses"}, 32'(pulses), 32'(n_pulses));
    endtask

    initial begin
        @(negedge clk);
        @(negedge clk);
        // Reset values while rst is held.
        check("rst_rx_ready", 32'(rx_ready), 32'd0);
        check("rst_flash_en", 32'(flash_en), 32'd0);
        check("rst_flash_addr", flash_addr, 32'd0);
        check("rst_flash_data", flash_data, 32'd0);
        check("rst_core_rst", 32'(core_rst), 32'd1);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_rx_ready", 32'(rx_ready), 32'd1);

        // Test 1: back-to-back stream.
        pulses = 0;
        push_img_writes();
        send_img(1'b0);
`ifdef BOOT_LOADER_CHECKSUM_EN
        send_byte(8'h0F, 1'b0);
`endif
        expect_done("t1", 3);
        // Bytes offered in DONE are not consumed.
        rx_valid = 1'b1;
        rx_data  = 8'h55;
        repeat (3) @(negedge clk);
        check("t1_hold_rx_ready", 32'(rx_ready), 32'd0);
        check("t1_hold_done", 32'(done), 32'd1);
        rx_valid = 1'b0;

        // Test 2: valid toggling every cycle.
        do_reset(1);
        pulses = 0;
        push_img_writes();
        send_img(1'b1);
`ifdef BOOT_LOADER_CHECKSUM_EN
        send_byte(8'h0F, 1'b1);
`endif
        expect_done("t2", 3);

        // Test 3: oversize count -> error right after the second byte.
        do_reset(1);
        pulses = 0;
        send_byte(8'h01, 1'b0);
        send_byte(8'h02, 1'b0);
        check("t3_err_next_cycle", 32'(err), 32'd1);
        check("t3_core_rst", 32'(core_rst), 32'd1);
        check("t3_rx_ready", 32'(rx_ready), 32'd0);
        repeat (10) @(negedge clk);
        expect_err("t3", 0);

        // Test 4: empty image.
        do_reset(1);
        pulses = 0;
        send_byte(8'h00, 1'b0);
        send_byte(8'h00, 1'b0);
`ifdef BOOT_LOADER_CHECKSUM_EN
        check("t4_waits_chk", 32'(done), 32'd0);
        send_byte(8'h00, 1'b0);
`endif
        expect_done("t4", 0);

        // Test 5: reset after 6 payload bytes, then a full reload.
        do_reset(1);
        pulses = 0;
        exp_q.push_back('{addr: 32'h0, data: 32'h00c64633});
        for (int i = 0; i < 8; i++) send_byte(img[i], 1'b0);
        check("t5_partial_pulses", 32'(pulses), 32'd1);
        do_reset(1);
        check("t5_rst_core_rst", 32'(core_rst), 32'd1);
        check("t5_rst_addr", flash_addr, 32'd0);
        pulses = 0;
        push_img_writes();
        send_img(1'b0);
`ifdef BOOT_LOADER_CHECKSUM_EN
        send_byte(8'h0F, 1'b0);
`endif
        expect_done("t5", 3);

`ifdef BOOT_LOADER_CHECKSUM_EN
        // Test 6: wrong checksum.
        do_reset(1);
        pulses = 0;
        push_img_writes();
        send_img(1'b0);
        send_byte(8'h0E, 1'b0);
        expect_err("t6", 3);
        check("t6_queue_empty", 32'(exp_q.size()), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
